// File: rtl/dmem_arb_pkg.sv
// Shared types for the DataMemory arbiter: FSM state encoding, default widths,
// and the latched request record.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  // Wide enough for RD_LAT up to 7.
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] adr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the DataMemory bus. The slave modport is
// the arbiter's view; the master modport is the requesters-plus-memory side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0, we0, gnt0, rvalid0;
  logic [ADDR_W-1:0] adr0;
  logic [DATA_W-1:0] wdata0, rdata0;

  logic              req1, we1, gnt1, rvalid1;
  logic [ADDR_W-1:0] adr1;
  logic [DATA_W-1:0] wdata1, rdata1;

  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] datain, dataout;
  logic              w, r;

  modport slave (
    input  req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, dataout,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, adr, datain, w, r
  );

  modport master (
    output req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, dataout,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, adr, datain, w, r
  );
endinterface

// File: rtl/dmem_rr_sel.sv
// Two-way request picker producing a one-hot grant. Defining
// DMEM_ARB_FIXED_PRIO_EN ignores the pointer and always favours port 0.
module dmem_rr_sel (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       rr_ptr_i,
  output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr_i;
  assign gnt_o[0]      = req0_i;
  assign gnt_o[1]      = req1_i & ~req0_i;
`else
  // rr_ptr_i names the port that wins a tie.
  assign gnt_o[0] = req0_i & (~req1_i | ~rr_ptr_i);
  assign gnt_o[1] = req1_i & (~req0_i |  rr_ptr_i);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port DataMemory with RD_LAT read latency.
// Round-robin by default; define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [1:0]        pick;
  logic              sample;

  dmem_rr_sel u_sel (
    .req0_i  (bus.req0),
    .req1_i  (bus.req1),
    .rr_ptr_i(rr_q),
    .gnt_o   (pick)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    sample    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          owner_d = pick[1];
          rr_d    = ~pick[1];
          req_d   = pick[1] ? '{we: bus.we1, adr: bus.adr1, wdata: bus.wdata1}
                            : '{we: bus.we0, adr: bus.adr0, wdata: bus.wdata0};
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (req_q.we) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last latency cycle: dataout is valid now, pulse rvalid in the following IDLE.
        if (cnt_q == CNT_W'(1)) begin
          sample    = 1'b1;
          state_d   = IDLE;
          rvalid0_d = ~owner_q;
          rvalid1_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      if (sample && !owner_q) rdata0_q <= bus.dataout;
      if (sample &&  owner_q) rdata1_q <= bus.dataout;
    end
  end

  assign bus.gnt0    = (state_q == IDLE) & pick[0];
  assign bus.gnt1    = (state_q == IDLE) & pick[1];
  assign bus.adr     = req_q.adr;
  assign bus.datain  = req_q.wdata;
  assign bus.w       = (state_q == ACCESS) &  req_q.we;
  assign bus.r       = (state_q == ACCESS) & ~req_q.we;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: RD_LAT=1 main instance with a memory model,
// plus an RD_LAT=3 instance with a ROM model for the latency scenario.
module tb_dmem_arbiter;

  localparam int RD_LAT  = 1;
  localparam int RD_LAT2 = 3;
  localparam int L       = 2 + RD_LAT;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus  ();
  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT2)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  // DataMemory model: write on w, read data appears RD_LAT cycles after the r cycle.
  logic [7:0] mem  [256];
  logic [7:0] pipe [RD_LAT];
  logic [7:0] pipe2[RD_LAT2];
  logic       pre_we;
  logic [7:0] pre_adr, pre_dat;

  always @(posedge clk) begin
    if (pre_we)     mem[pre_adr] <= pre_dat;
    else if (bus.w) mem[bus.adr] <= bus.datain;
    pipe[0] <= bus.r ? mem[bus.adr] : 8'hEE;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.dataout = pipe[RD_LAT-1];

  always @(posedge clk) begin
    pipe2[0] <= bus2.r ? (bus2.adr ^ 8'hA5) : 8'hEE;
    pipe2[1] <= pipe2[0];
    pipe2[2] <= pipe2[1];
  end
  assign bus2.dataout = pipe2[RD_LAT2-1];

  int         n_tests;
  int         n_fail;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];

  task automatic idle_inputs();
    bus.req0  = 1'b0; bus.we0  = 1'b0; bus.adr0  = '0; bus.wdata0  = '0;
    bus.req1  = 1'b0; bus.we1  = 1'b0; bus.adr1  = '0; bus.wdata1  = '0;
    bus2.req0 = 1'b0; bus2.we0 = 1'b0; bus2.adr0 = '0; bus2.wdata0 = '0;
    bus2.req1 = 1'b0; bus2.we1 = 1'b0; bus2.adr1 = '0; bus2.wdata1 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample point: exclusivity invariants plus the read-data scoreboard.
  task automatic mid();
    logic [7:0] e;
    @(negedge clk);
    n_tests++;
    if ((bus.gnt0 & bus.gnt1) !== 1'b0 || (bus.w & bus.r) !== 1'b0) begin
      n_fail++;
      $display("FAIL exclusivity: gnt0/gnt1=%b%b w/r=%b%b, required never both", bus.gnt0, bus.gnt1, bus.w, bus.r);
    end
    if (bus.rvalid0 === 1'b1) begin
      n_tests++;
      if (exp_q0.size() == 0) begin
        n_fail++;
        $display("FAIL sb_rvalid0: unexpected pulse with rdata0=%h, required no pulse", bus.rdata0);
      end else begin
        e = exp_q0.pop_front();
        if (bus.rdata0 !== e) begin
          n_fail++;
          $display("FAIL sb_rdata0: got %h, required %h", bus.rdata0, e);
        end
      end
    end
    if (bus.rvalid1 === 1'b1) begin
      n_tests++;
      if (exp_q1.size() == 0) begin
        n_fail++;
        $display("FAIL sb_rvalid1: unexpected pulse with rdata1=%h, required no pulse", bus.rdata1);
      end else begin
        e = exp_q1.pop_front();
        if (bus.rdata1 !== e) begin
          n_fail++;
          $display("FAIL sb_rdata1: got %h, required %h", bus.rdata1, e);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    mid(); tick();
    mid(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    mid(); tick();
    mid();
    n_tests++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.w, bus.r} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt/rvalid/w/r=%b, required 000000",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.w, bus.r});
    end
    n_tests++;
    if ({bus.adr, bus.datain, bus.rdata0, bus.rdata1} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: adr/datain/rdata0/rdata1=%h, required 00000000",
               {bus.adr, bus.datain, bus.rdata0, bus.rdata1});
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      mid();
      n_tests++;
      if ({bus.w, bus.r, bus.gnt0, bus.gnt1} !== 4'b0) begin
        n_fail++;
        $display("FAIL idle_quiet: cycle %0d w/r/gnt0/gnt1=%b, required 0000", c, {bus.w, bus.r, bus.gnt0, bus.gnt1});
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 8'h0A; bus.wdata0 = 8'h55;
    mid();
    n_tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_grant: gnt0/gnt1=%b, required 10", {bus.gnt0, bus.gnt1});
    end
    tick();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.wdata0 = 8'h00;
    mid();
    n_tests++;
    if ({bus.w, bus.r, bus.adr, bus.datain} !== {2'b10, 8'h0A, 8'h55}) begin
      n_fail++;
      $display("FAIL wr_access: w/r=%b adr=%h datain=%h, required w/r=10 adr=0a datain=55",
               {bus.w, bus.r}, bus.adr, bus.datain);
    end
    tick();
    bus.req0 = 1'b1;
    mid();
    n_tests++;
    if ({bus.w, bus.r, bus.gnt0} !== 3'b001) begin
      n_fail++;
      $display("FAIL rd_grant_after_write: w/r/gnt0=%b, required 001", {bus.w, bus.r, bus.gnt0});
    end
    exp_q0.push_back(8'h55);
    tick();
    bus.req0 = 1'b0;
    mid();
    n_tests++;
    if ({bus.w, bus.r, bus.adr} !== {2'b01, 8'h0A}) begin
      n_fail++;
      $display("FAIL rd_access: w/r=%b adr=%h, required w/r=01 adr=0a", {bus.w, bus.r}, bus.adr);
    end
    for (int k = 2; k <= RD_LAT + 1; k++) begin
      tick(); mid();
      n_tests++;
      if ({bus.rvalid0, bus.w, bus.r} !== 3'b000) begin
        n_fail++;
        $display("FAIL rd_wait: T+%0d rvalid0/w/r=%b, required 000", k, {bus.rvalid0, bus.w, bus.r});
      end
    end
    tick(); mid();
    n_tests++;
    if (bus.rvalid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_rvalid_time: rvalid0=%b at T+%0d, required 1", bus.rvalid0, L);
    end
    tick(); mid();
    n_tests++;
    if ({bus.rvalid0, bus.rdata0} !== {1'b0, 8'h55}) begin
      n_fail++;
      $display("FAIL rd_pulse_hold: rvalid0=%b rdata0=%h, required rvalid0=0 rdata0=55", bus.rvalid0, bus.rdata0);
    end
    n_tests++;
    if (exp_q0.size() != 0) begin
      n_fail++;
      $display("FAIL rd_outstanding: %0d reads never returned, required 0", exp_q0.size());
    end
    tick();
  endtask

  task automatic test_contention();
    int         g1_at  = -1;
    int         rv0_at = -1;
    int         rv1_at = -1;
    int         extra_g0 = 0;
    bit         drop1  = 1'b0;
    logic [7:0] rd1_at_rv0 = 'x;
    logic [7:0] rd0_at_rv1 = 'x;
    rst_n = 1'b0;
    idle_inputs();
    pre_we = 1'b1; pre_adr = 8'h01; pre_dat = 8'h11;
    mid(); tick();
    pre_adr = 8'h02; pre_dat = 8'h22;
    mid(); tick();
    pre_we = 1'b0;
    rst_n  = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 8'h01;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 8'h02;
    mid();
    n_tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL cont_first_grant: gnt0/gnt1=%b, required 10", {bus.gnt0, bus.gnt1});
    end
    exp_q0.push_back(8'h11);
    tick();
    bus.req0 = 1'b0;
    for (int c = 1; c < 40 && rv1_at < 0; c++) begin
      mid();
      if (bus.gnt0 === 1'b1) extra_g0++;
      if (bus.gnt1 === 1'b1 && g1_at < 0) begin
        g1_at = c;
        drop1 = 1'b1;
        exp_q1.push_back(8'h22);
      end
      if (bus.rvalid0 === 1'b1) begin rv0_at = c; rd1_at_rv0 = bus.rdata1; end
      if (bus.rvalid1 === 1'b1) begin rv1_at = c; rd0_at_rv1 = bus.rdata0; end
      tick();
      if (drop1) bus.req1 = 1'b0;
    end
    n_tests++;
    if (g1_at != L) begin
      n_fail++;
      $display("FAIL cont_gnt1_time: gnt1 at T+%0d, required T+%0d", g1_at, L);
    end
    n_tests++;
    if (rv0_at != L) begin
      n_fail++;
      $display("FAIL cont_rvalid0_time: rvalid0 at T+%0d, required T+%0d", rv0_at, L);
    end
    n_tests++;
    if (rv1_at != 2 * L) begin
      n_fail++;
      $display("FAIL cont_rvalid1_time: rvalid1 at T+%0d, required T+%0d", rv1_at, 2 * L);
    end
    n_tests++;
    if (rd1_at_rv0 !== 8'h00) begin
      n_fail++;
      $display("FAIL cont_rdata1_undisturbed: rdata1=%h during rvalid0, required 00", rd1_at_rv0);
    end
    n_tests++;
    if (rd0_at_rv1 !== 8'h11) begin
      n_fail++;
      $display("FAIL cont_rdata0_hold: rdata0=%h during rvalid1, required 11", rd0_at_rv1);
    end
    n_tests++;
    if (extra_g0 != 0) begin
      n_fail++;
      $display("FAIL cont_extra_gnt0: %0d extra port-0 grants, required 0", extra_g0);
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    int         order[8];
    int         gcyc[8];
    logic [7:0] gadr[8];
    logic [7:0] gdat[8];
    int         ng = 0;
    int         p0 = 0;
    int         p1 = 0;
    logic       g0, g1;
    for (int k = 0; k < 8; k++) begin order[k] = -1; gcyc[k] = 0; gadr[k] = '0; gdat[k] = 'x; end
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 8'h20; bus.wdata0 = 8'hA0;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.adr1 = 8'h30; bus.wdata1 = 8'hB0;
    for (int c = 0; c < 60 && ng < 8; c++) begin
      mid();
      g0 = bus.gnt0;
      g1 = bus.gnt1;
      if (g0 === 1'b1) begin
        order[ng] = 0; gcyc[ng] = c; gadr[ng] = bus.adr0; gdat[ng] = bus.wdata0; ng++;
      end else if (g1 === 1'b1) begin
        order[ng] = 1; gcyc[ng] = c; gadr[ng] = bus.adr1; gdat[ng] = bus.wdata1; ng++;
      end
      tick();
      if (g0 === 1'b1) begin p0++; bus.adr0 = 8'h20 + 8'(p0); bus.wdata0 = 8'hA0 + 8'(p0); end
      if (g1 === 1'b1) begin p1++; bus.adr1 = 8'h30 + 8'(p1); bus.wdata1 = 8'hB0 + 8'(p1); end
    end
    idle_inputs();
    mid(); tick();
    mid(); tick();
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (order[k] != (FIXED_PRIO ? 0 : k % 2)) begin
        n_fail++;
        $display("FAIL fair_order: grant %0d went to port %0d, required port %0d", k, order[k], FIXED_PRIO ? 0 : k % 2);
      end
      n_tests++;
      if (mem[gadr[k]] !== gdat[k]) begin
        n_fail++;
        $display("FAIL fair_mem: mem[%h]=%h after write %0d, required %h", gadr[k], mem[gadr[k]], k, gdat[k]);
      end
    end
    n_tests++;
    if (gcyc[7] - gcyc[0] != 14) begin
      n_fail++;
      $display("FAIL fair_throughput: 8 writes spanned %0d cycles, required 14", gcyc[7] - gcyc[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 8'h0A;
    mid();
    n_tests++;
    if (bus.gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rmr_grant: gnt0=%b, required 1", bus.gnt0);
    end
    tick();
    bus.req0 = 1'b0;
    mid(); tick();
    rst_n = 1'b0;
    mid(); tick();
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 8'h40; bus.wdata0 = 8'h77;
    mid();
    n_tests++;
    if ({bus.rvalid0, bus.w, bus.r, bus.gnt0, bus.rdata0} !== {4'b0001, 8'h00}) begin
      n_fail++;
      $display("FAIL rmr_after_reset: rvalid0/w/r/gnt0=%b rdata0=%h, required 0001 rdata0=00",
               {bus.rvalid0, bus.w, bus.r, bus.gnt0}, bus.rdata0);
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 6; c++) begin mid(); tick(); end
    n_tests++;
    if (mem[8'h40] !== 8'h77) begin
      n_fail++;
      $display("FAIL rmr_write: mem[40]=%h, required 77", mem[8'h40]);
    end
  endtask

  task automatic test_rd_lat3();
    logic [7:0] e;
    do_reset();
    bus2.req0 = 1'b1; bus2.we0 = 1'b0; bus2.adr0 = 8'h3C;
    bus2.req1 = 1'b1; bus2.we1 = 1'b1; bus2.adr1 = 8'h01; bus2.wdata1 = 8'h99;
    mid();
    n_tests++;
    if ({bus2.gnt0, bus2.gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL lat3_grant: gnt0/gnt1=%b, required 10", {bus2.gnt0, bus2.gnt1});
    end
    exp_q2.push_back(8'h3C ^ 8'hA5);
    tick();
    bus2.req0 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      mid();
      if (c == 1) begin
        n_tests++;
        if ({bus2.w, bus2.r} !== 2'b01) begin
          n_fail++;
          $display("FAIL lat3_r: w/r=%b at T+1, required 01", {bus2.w, bus2.r});
        end
      end
      if (c <= 4) begin
        n_tests++;
        if ({bus2.gnt0, bus2.gnt1, bus2.rvalid0} !== 3'b000) begin
          n_fail++;
          $display("FAIL lat3_busy: gnt0/gnt1/rvalid0=%b at T+%0d, required 000", {bus2.gnt0, bus2.gnt1, bus2.rvalid0}, c);
        end
      end else begin
        n_tests++;
        if ({bus2.rvalid0, bus2.gnt1} !== 2'b11) begin
          n_fail++;
          $display("FAIL lat3_done: rvalid0/gnt1=%b at T+5, required 11", {bus2.rvalid0, bus2.gnt1});
        end
      end
      if (bus2.rvalid0 === 1'b1) begin
        n_tests++;
        if (exp_q2.size() == 0) begin
          n_fail++;
          $display("FAIL lat3_sb: unexpected rvalid0 with rdata0=%h", bus2.rdata0);
        end else begin
          e = exp_q2.pop_front();
          if (bus2.rdata0 !== e) begin
            n_fail++;
            $display("FAIL lat3_rdata: got %h, required %h", bus2.rdata0, e);
          end
        end
      end
      tick();
    end
    idle_inputs();
    mid(); tick();
    n_tests++;
    if (exp_q2.size() != 0) begin
      n_fail++;
      $display("FAIL lat3_outstanding: %0d reads never returned, required 0", exp_q2.size());
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    pre_we  = 1'b0;
    pre_adr = '0;
    pre_dat = '0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_reset_mid_read();
    test_rd_lat3();
    n_tests++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL final_outstanding: %0d/%0d reads pending, required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
